smac_sequencer: RTL and testbench
=================================

// Module: smac_sequencer
// PURPOSE
//  Host-side driver for one smac lane. It accepts a dot-product command, then streams operand
//  pairs into the smac port set (ce/sclr/data_input/weight/precision/fp/chain). After the
//  smac pipeline has flushed, it captures res_mac_p and returns it on a valid/ready result port.
//  Sits between the dtpu operand buffers and the smac array, one instance per lane.
// PARAMETERS
//  BIT_WIDTH    8    base lane width; all data buses are BIT_WIDTH*BIT_WIDTH bits (BUS_W)
//  MAC_LATENCY  3    smac pipeline depth, counted in ce-enabled cycles
//  LEN_W        9    width of cmd_len; maximum length is 2**LEN_W-1 operand pairs
// PORTS
//  clk                  in   1      clock
//  rstb                 in   1      asynchronous active-low reset
//  srst                 in   1      synchronous abort: return to IDLE and drop the current job
//  cmd_valid/cmd_ready  in/out 1/1  command handshake
//  cmd_len              in   LEN_W  number of operand pairs to accumulate
//  cmd_precision        in   4      forwarded to smac select_precision
//  cmd_fp               in   2      forwarded to smac enable_fp_unit
//  cmd_chain            in   1      forwarded to smac active_chain
//  op_valid/op_ready    in/out 1/1  operand-pair handshake
//  op_data, op_weight   in   BUS_W  operand pair
//  mac_ce, mac_sclr     out  1/1    smac ce and sclr
//  mac_data, mac_weight out  BUS_W  smac data_input and weight
//  mac_prec/mac_fp/mac_chain out 4/2/1  smac configuration, held stable for the whole job
//  mac_res_p            in   BUS_W  smac res_mac_p
//  res_valid/res_ready  out/in 1/1  result handshake
//  res_data             out  BUS_W  captured accumulation
// BEHAVIOUR
//  Reset (rstb=0 or srst=1): state=IDLE; every output is 0 except cmd_ready=1.
//  All mac_* outputs are registered. FSM states: IDLE -> CLEAR -> FEED -> DRAIN -> OUT -> IDLE.
//  IDLE:  cmd_ready=1. On cmd_valid, latch len/prec/fp/chain into the mac_* config registers,
//         clear cnt, go to CLEAR.
//  CLEAR: one cycle with mac_ce=1, mac_sclr=1, mac_data=mac_weight=0.
//         Next state is FEED if len!=0, otherwise DRAIN.
//  FEED:  op_ready=1 while cnt<len. Each op handshake registers the pair onto mac_data/mac_weight
//         with mac_ce=1 in the following cycle and increments cnt. A cycle without a handshake
//         drives mac_ce=0, which freezes smac; data stays at its previous value.
//         When the handshake that makes cnt==len occurs, op_ready drops in the next cycle and the
//         FSM goes to DRAIN.
//  DRAIN: MAC_LATENCY cycles with mac_ce=1 and zero operands (contributes 0 to the sum), then one
//         more cycle with mac_ce=0 in which mac_res_p is sampled into res_data. Then go to OUT.
//  OUT:   res_valid=1 with res_data held stable until res_ready. On handshake go to IDLE;
//         res_valid falls in the next cycle.
//  Throughput: len + MAC_LATENCY + 3 cycles minimum per job; the result is not pipelined.
//  Boundaries:
//   - cmd_len=0: no operands are consumed and the returned result equals the cleared smac value
//     (0).
//   - cmd_len=2**LEN_W-1: cnt must not wrap; the compare is done at LEN_W bits.
//   - op_valid asserted in any state other than FEED is ignored (op_ready=0).
//   - cmd_valid is ignored outside IDLE; the config cannot change mid-job.
//   - srst takes priority over every handshake in the same cycle. rstb mid-job aborts the job
//     asynchronously and produces no result.
//   - res_ready held low: the FSM holds in OUT indefinitely with no other side effect.
// STRUCTURE
//  Package dtpu_pkg (shared):
//   - BIT_WIDTH / BUS_W localparams
//   - typedef enum logic[2:0] smac_seq_state_t {IDLE,CLEAR,FEED,DRAIN,OUT}
//   - typedef struct packed smac_cfg_t {prec[3:0]; fp[1:0]; chain}
//  A single flat module; no sub-module is needed. The drain counter reuses cnt.
// TESTING (bench drives the smac ports with smac, USE_FABRIC="NO", BIT_WIDTH=8)
//  1 Reset: rstb low for 20ns -> cmd_ready=1, mac_ce=0, res_valid=0.
//    Then pulse srst mid-FEED -> IDLE next cycle, no result.
//  2 len=4, INT8, op_data=op_weight=lane-wise 2 every cycle ->
//    res_data=16 per lane, res_valid 4+3+3 cycles after CLEAR.
//  3 Same job with op_valid toggling 1,0,1,0 ->
//    mac_ce mirrors the handshakes one cycle later, result still 16, latency +3 cycles.
//  4 len=0 -> no op_ready pulse, res_data=0, a single mac_sclr pulse seen.
//  5 res_ready held low 10 cycles -> res_data stable, cmd_ready=0; release -> IDLE, accepts the
//    next command.
//  6 Back-to-back jobs with cmd_precision 4'h1 then 4'h2 ->
//    mac_prec changes only in the CLEAR cycle of job 2; each result matches the golden model.

Source files
------------

// File: rtl/dtpu_pkg.sv
// Shared dtpu types: lane geometry, smac sequencer FSM encoding and the per-job smac configuration.
package dtpu_pkg;

  localparam int BIT_WIDTH = 8;
  localparam int BUS_W     = BIT_WIDTH * BIT_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    OUT
  } smac_seq_state_t;

  typedef struct packed {
    logic [3:0] prec;
    logic [1:0] fp;
    logic       chain;
  } smac_cfg_t;

endpackage

// File: rtl/smac_sequencer.sv
// Host-side driver for one smac lane: takes a dot-product command, streams operand pairs into
// smac, waits out the pipeline and hands the accumulated result back on a valid/ready port.
module smac_sequencer
  import dtpu_pkg::*;
#(
  parameter int  BIT_WIDTH   = 8,
  parameter int  MAC_LATENCY = 3,
  parameter int  LEN_W       = 9,
  localparam int BUS_W       = BIT_WIDTH * BIT_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             srst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [3:0]       cmd_precision,
  input  logic [1:0]       cmd_fp,
  input  logic             cmd_chain,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [BUS_W-1:0] op_data,
  input  logic [BUS_W-1:0] op_weight,
  output logic             mac_ce,
  output logic             mac_sclr,
  output logic [BUS_W-1:0] mac_data,
  output logic [BUS_W-1:0] mac_weight,
  output logic [3:0]       mac_prec,
  output logic [1:0]       mac_fp,
  output logic             mac_chain,
  input  logic [BUS_W-1:0] mac_res_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BUS_W-1:0] res_data
);

  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(MAC_LATENCY);

  smac_seq_state_t  state_reg;
  smac_cfg_t        cfg_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [LEN_W-1:0] cnt_next;

  // cnt serves as the operand counter in FEED and as the flush counter in DRAIN.
  assign cnt_next  = cnt_reg + LEN_W'(1);
  assign mac_prec  = cfg_reg.prec;
  assign mac_fp    = cfg_reg.fp;
  assign mac_chain = cfg_reg.chain;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg  <= IDLE;
      cfg_reg    <= '0;
      len_reg    <= '0;
      cnt_reg    <= '0;
      cmd_ready  <= 1'b1;
      op_ready   <= 1'b0;
      mac_ce     <= 1'b0;
      mac_sclr   <= 1'b0;
      mac_data   <= '0;
      mac_weight <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else if (srst) begin
      state_reg  <= IDLE;
      cfg_reg    <= '0;
      len_reg    <= '0;
      cnt_reg    <= '0;
      cmd_ready  <= 1'b1;
      op_ready   <= 1'b0;
      mac_ce     <= 1'b0;
      mac_sclr   <= 1'b0;
      mac_data   <= '0;
      mac_weight <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            cfg_reg    <= '{prec: cmd_precision, fp: cmd_fp, chain: cmd_chain};
            len_reg    <= cmd_len;
            cnt_reg    <= '0;
            cmd_ready  <= 1'b0;
            mac_ce     <= 1'b1;
            mac_sclr   <= 1'b1;
            mac_data   <= '0;
            mac_weight <= '0;
            state_reg  <= CLEAR;
          end
        end

        CLEAR: begin
          mac_sclr <= 1'b0;
          if (len_reg != '0) begin
            op_ready  <= 1'b1;
            mac_ce    <= 1'b0;
            state_reg <= FEED;
          end else begin
            mac_ce    <= 1'b1;
            state_reg <= DRAIN;
          end
        end

        FEED: begin
          if (op_ready) begin
            if (op_valid) begin
              mac_ce     <= 1'b1;
              mac_data   <= op_data;
              mac_weight <= op_weight;
              cnt_reg    <= cnt_next;
              op_ready   <= (cnt_next != len_reg);
            end else begin
              mac_ce <= 1'b0;
            end
          end else begin
            // The last pair is on the smac inputs this cycle; start zero-filling after it.
            cnt_reg    <= '0;
            mac_ce     <= 1'b1;
            mac_data   <= '0;
            mac_weight <= '0;
            state_reg  <= DRAIN;
          end
        end

        DRAIN: begin
          if (cnt_reg == DRAIN_LAST) begin
            res_data  <= mac_res_p;
            res_valid <= 1'b1;
            state_reg <= OUT;
          end else begin
            cnt_reg <= cnt_next;
            mac_ce  <= (cnt_next != DRAIN_LAST);
          end
        end

        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smac_sequencer.sv
// Bench for smac_sequencer: a behavioural 3-stage lane-wise smac closes the loop, a scoreboard
// holds golden dot products, and a vector table plus hand sequences exercise the corner cases.
`timescale 1ns/1ps
module tb_smac_sequencer;
  import dtpu_pkg::*;

  localparam int LEN_W = 9;
  localparam int MAC_L = 3;

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             srst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [3:0]       cmd_precision = '0;
  logic [1:0]       cmd_fp = '0;
  logic             cmd_chain = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [BUS_W-1:0] op_data = '0;
  logic [BUS_W-1:0] op_weight = '0;
  logic             mac_ce, mac_sclr;
  logic [BUS_W-1:0] mac_data, mac_weight, mac_res_p;
  logic [3:0]       mac_prec;
  logic [1:0]       mac_fp;
  logic             mac_chain;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [BUS_W-1:0] res_data;

  always #5 clk = ~clk;

  smac_sequencer #(.BIT_WIDTH(8), .MAC_LATENCY(MAC_L), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstb(rstb), .srst(srst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_precision(cmd_precision), .cmd_fp(cmd_fp), .cmd_chain(cmd_chain),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_weight(op_weight),
    .mac_ce(mac_ce), .mac_sclr(mac_sclr), .mac_data(mac_data), .mac_weight(mac_weight),
    .mac_prec(mac_prec), .mac_fp(mac_fp), .mac_chain(mac_chain), .mac_res_p(mac_res_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  function automatic logic [BUS_W-1:0] lane_mul(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b);
    logic [BUS_W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = a[k*8 +: 8] * b[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [BUS_W-1:0] lane_add(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b);
    logic [BUS_W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = a[k*8 +: 8] + b[k*8 +: 8];
    return r;
  endfunction

  // smac stand-in: product stage, pipe stage, accumulate stage; all advance only on ce.
  logic [BUS_W-1:0] s1_prod, s2_prod, acc;
  logic             s1_clr, s2_clr;
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_prod <= '0; s2_prod <= '0; acc <= '0; s1_clr <= 1'b0; s2_clr <= 1'b0;
    end else if (mac_ce) begin
      s1_prod <= lane_mul(mac_data, mac_weight);
      s1_clr  <= mac_sclr;
      s2_prod <= s1_prod;
      s2_clr  <= s1_clr;
      acc     <= s2_clr ? '0 : lane_add(acc, s2_prod);
    end
  end
  assign mac_res_p = acc;

  typedef struct {
    int               len;
    logic [3:0]       prec;
    logic [1:0]       fp;
    logic             chain;
    logic [BUS_W-1:0] dseed;
    logic [BUS_W-1:0] wseed;
    logic [7:0]       step;
    bit               toggle;
    int               hold;
    bit               noise;
    logic [BUS_W-1:0] exp_res;
    int               exp_lat;
  } vec_t;

  function automatic logic [BUS_W-1:0] opv(input logic [BUS_W-1:0] seed, input logic [7:0] step, input int i);
    logic [BUS_W-1:0] r;
    logic [7:0]       i8;
    i8 = i[7:0];
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = seed[k*8 +: 8] + step * i8;
    return r;
  endfunction

  function automatic logic [BUS_W-1:0] golden(input vec_t v);
    logic [BUS_W-1:0] s;
    s = '0;
    for (int i = 0; i < v.len; i++)
      s = lane_add(s, lane_mul(opv(v.dseed, v.step, i), opv(v.wseed, v.step, i)));
    return s;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int clear_cyc = 0;
  int hs_cnt = 0, rdy_cnt = 0, sclr_cnt = 0;
  logic [6:0] cur_cfg = '0;
  logic [6:0] cfg_prev = '0;
  logic [BUS_W-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: sclr/config tracking, handshake counters and scoreboard pop at the result handshake.
  initial forever begin
    @(negedge clk);
    if (rstb) begin
      if (mac_sclr) begin
        sclr_cnt++;
        clear_cyc = cyc;
        chk("cfg_at_clear", {57'd0, mac_prec, mac_fp, mac_chain}, {57'd0, cur_cfg});
      end else if (!cmd_ready) begin
        chk("cfg_stable_midjob", {57'd0, mac_prec, mac_fp, mac_chain}, {57'd0, cfg_prev});
      end
      if (op_ready) rdy_cnt++;
      if (op_valid && op_ready) hs_cnt++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_result", 64'd1, 64'd0);
        else chk("sb_result", res_data, exp_q.pop_front());
      end
    end
    cfg_prev = {mac_prec, mac_fp, mac_chain};
  end

  task automatic issue_cmd(input int len, input logic [3:0] prec, input logic [1:0] fp,
                           input logic chain, output bit ok);
    int guard;
    cur_cfg = {prec, fp, chain};
    hs_cnt = 0; rdy_cnt = 0; sclr_cnt = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = LEN_W'(len);
    cmd_precision = prec; cmd_fp = fp; cmd_chain = chain;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
      guard++;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_job(input vec_t v, input int idx);
    bit ok, phase, hs;
    int i, guard, lat, exp_rdy;
    issue_cmd(v.len, v.prec, v.fp, v.chain, ok);
    exp_q.push_back(v.exp_res);
    if (v.noise) begin
      cmd_valid = 1'b1; cmd_precision = ~v.prec; cmd_fp = ~v.fp; cmd_len = LEN_W'(3);
    end
    i = 0; phase = 1'b1; guard = 0;
    while (i < v.len && guard < 5000) begin
      op_valid  = v.toggle ? phase : 1'b1;
      op_data   = opv(v.dseed, v.step, i);
      op_weight = opv(v.wseed, v.step, i);
      @(negedge clk);
      hs = op_valid && op_ready;
      if (op_ready) phase = ~phase;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    if (i < v.len) chk("feed_timeout", 64'(i), 64'(v.len));
    op_valid = v.noise; op_data = '1; op_weight = '1;
    guard = 0;
    @(negedge clk);
    while (!res_valid && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b0;
    chk("res_valid_seen", 64'(res_valid), 64'd1);
    lat = cyc - clear_cyc;
    chk("latency", 64'(lat), 64'(v.exp_lat));
    chk("sclr_pulses", 64'(sclr_cnt), 64'd1);
    chk("op_handshakes", 64'(hs_cnt), 64'(v.len));
    exp_rdy = v.toggle ? ((v.len == 0) ? 0 : 2 * v.len - 1) : v.len;
    chk("op_ready_cycles", 64'(rdy_cnt), 64'(exp_rdy));
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_res_data", res_data, v.exp_res);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      @(negedge clk);
    end
    op_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_dropped", 64'(res_valid), 64'd0);
    chk("back_to_idle", 64'(cmd_ready), 64'd1);
    $display("job %0d len=%0d prec=%h toggle=%0d hold=%0d result=%h latency=%0d",
             idx, v.len, v.prec, v.toggle, v.hold, res_data, lat);
  endtask

  vec_t tbl[7];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt, guard;

    tbl[0] = '{4, 4'h1, 2'd0, 1'b0, {8{8'h02}}, {8{8'h02}}, 8'd0, 1'b0, 0, 1'b0, {8{8'h10}}, 10};
    tbl[1] = '{4, 4'h2, 2'd1, 1'b1, {8{8'h02}}, {8{8'h02}}, 8'd0, 1'b1, 0, 1'b0, {8{8'h10}}, 13};
    tbl[2] = '{0, 4'h3, 2'd2, 1'b0, {8{8'h55}}, {8{8'h33}}, 8'd1, 1'b0, 0, 1'b0, 64'd0, 5};
    tbl[3] = '{4, 4'h1, 2'd0, 1'b1, {8{8'h02}}, {8{8'h02}}, 8'd0, 1'b0, 10, 1'b1, {8{8'h10}}, 10};
    tbl[4] = '{5, 4'h4, 2'd3, 1'b0, 64'h0807060504030201, 64'h0102030405060708, 8'd1, 1'b0, 0, 1'b0, 64'd0, 11};
    tbl[5] = '{31, 4'h8, 2'd1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 8'd7, 1'b1, 2, 1'b0, 64'd0, 67};
    tbl[6] = '{511, 4'hF, 2'd3, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 8'd3, 1'b0, 0, 1'b1, 64'd0, 517};
    for (int k = 4; k < 7; k++) tbl[k].exp_res = golden(tbl[k]);

    // Reset: outputs at their reset values while rstb is low.
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_mac_ce", 64'(mac_ce), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    #8 rstb = 1'b1;

    // srst mid-FEED, colliding with op and cmd handshakes.
    issue_cmd(4, 4'h5, 2'd1, 1'b0, ok);
    op_valid = 1'b1; op_data = {8{8'h03}}; op_weight = {8{8'h03}};
    guard = 0;
    while (hs_cnt < 2 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    srst = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0; cmd_valid = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("srst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("srst_op_ready", 64'(op_ready), 64'd0);
    chk("srst_mac_ce", 64'(mac_ce), 64'd0);
    chk("srst_mac_prec", 64'(mac_prec), 64'd0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) cnt++;
      @(negedge clk);
    end
    chk("srst_no_result", 64'(cnt), 64'd0);
    $display("job srst-abort len=4 aborted after %0d pairs", hs_cnt);

    // Asynchronous rstb mid-job: immediate abort, no result.
    issue_cmd(3, 4'h6, 2'd2, 1'b1, ok);
    op_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rstb = 1'b0;
    #1;
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("arst_mac_ce", 64'(mac_ce), 64'd0);
    chk("arst_op_ready", 64'(op_ready), 64'd0);
    chk("arst_mac_data", mac_data, 64'd0);
    op_valid = 1'b0;
    @(negedge clk); #2;
    rstb = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    chk("arst_no_result", 64'(cnt), 64'd0);
    $display("job rstb-abort len=3 aborted");

    for (int k = 0; k < 7; k++) run_job(tbl[k], k);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
